// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router constants and the local-port grant vector type
package noc_pkg;
    localparam int FLIT_WIDTH = 32;
    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;
    typedef logic [4:0] port_vec_t;
    typedef enum logic {HS_IDLE = 1'b0, HS_ACK = 1'b1} hs_state_t;
endpackage

// File: rtl/noc_fifo_mem.sv
// noc_fifo_mem: DEPTH x DATA_WIDTH register array, one write port, async read port
module noc_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // storage is cleared on reset so the head reads zero until the first write
    always_ff @(posedge clk or posedge rst)
        if (rst) mem <= '{default: '0};
        else if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/noc_input_fifo_rx.sv
// noc_input_fifo_rx: router input port, RTS/CTS receive handshake feeding a small flit FIFO
module noc_input_fifo_rx
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    output logic                  CTS,
    input  port_vec_t             read_en,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  err_multi
);
    hs_state_t state, state_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    // handshake state register; the state bit is the CTS flop
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= HS_IDLE;
        else state <= state_next;
    // acknowledge for exactly one cycle, only when room was available
    always_comb
        state_next = (state == HS_IDLE && DRTS && !full) ? HS_ACK : HS_IDLE;
    // CTS decodes directly from the state register
    always_comb
        CTS = (state == HS_ACK);
    assign wr_en = CTS & DRTS;
    assign rd_en = |read_en & ~empty;
    assign empty = (count == '0);
    assign full = (count == CNT_W'(DEPTH));
    // pointers, occupancy and the sticky multi-grant flag
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            err_multi <= 1'b0;
        end else begin
            wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_en ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
            err_multi <= err_multi | (!empty && (read_en & (read_en - 1'b1)) != '0);
        end
    noc_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .rst(rst),
        .we(wr_en),
        .waddr(wr_ptr),
        .wdata(RX),
        .raddr(rd_ptr),
        .rdata(Data_out)
    );
endmodule

// File: tb/tb_noc_input_fifo_rx.sv
// tb_noc_input_fifo_rx: directed vector table plus handshake, wrap and async-reset sequences
module tb_noc_input_fifo_rx;
    import noc_pkg::*;
    logic clk = 0, rst = 1, DRTS = 0, CTS, empty, full, err_multi;
    logic [31:0] RX = 0, Data_out;
    port_vec_t read_en = 0;
    logic [2:0] count;
    int nchk = 0, nfail = 0;
    logic mon_on = 0;
    logic [31:0] got[$];

    noc_input_fifo_rx #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS), .CTS(CTS), .read_en(read_en),
        .Data_out(Data_out), .empty(empty), .full(full), .count(count), .err_multi(err_multi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic drts; logic [31:0] rx; logic [4:0] re;
        logic cts; logic [2:0] cnt; logic emp; logic ful; logic cd; logic [31:0] dat; logic err;
    } vec_t;
    vec_t tv[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        DRTS = 1; RX = d; n = 0;
        step();
        while (!CTS && n < 8) begin step(); n++; end
        chk("cts_timeout", CTS, 1);
        step();
        DRTS = 0;
    endtask

    // samples each accepted pop and bounds occupancy during streaming
    always @(negedge clk) if (mon_on) begin
        if (|read_en && !empty) got.push_back(Data_out);
        nchk++;
        if (count > 3'd2) begin
            nfail++;
            $display("FAIL wrap_count: got %0d expected <=2", count);
        end
    end

    initial begin
        tv[0]  = '{1, 32'hA5A50001, 5'd0, 1, 3'd0, 1, 0, 1, 32'h0, 0};
        tv[1]  = '{1, 32'hA5A50001, 5'd0, 0, 3'd1, 0, 0, 1, 32'hA5A50001, 0};
        tv[2]  = '{1, 32'h2, 5'd0, 1, 3'd1, 0, 0, 1, 32'hA5A50001, 0};
        tv[3]  = '{1, 32'h2, 5'd0, 0, 3'd2, 0, 0, 1, 32'hA5A50001, 0};
        tv[4]  = '{1, 32'h3, 5'd0, 1, 3'd2, 0, 0, 1, 32'hA5A50001, 0};
        tv[5]  = '{1, 32'h3, 5'd0, 0, 3'd3, 0, 0, 1, 32'hA5A50001, 0};
        tv[6]  = '{1, 32'h4, 5'd0, 1, 3'd3, 0, 0, 1, 32'hA5A50001, 0};
        tv[7]  = '{1, 32'h4, 5'd0, 0, 3'd4, 0, 1, 1, 32'hA5A50001, 0};
        tv[8]  = '{1, 32'h5, 5'd0, 0, 3'd4, 0, 1, 1, 32'hA5A50001, 0};
        tv[9]  = '{1, 32'h5, 5'd0, 0, 3'd4, 0, 1, 1, 32'hA5A50001, 0};
        tv[10] = '{1, 32'h5, 5'd1, 0, 3'd3, 0, 0, 1, 32'h2, 0};
        tv[11] = '{1, 32'h5, 5'd0, 1, 3'd3, 0, 0, 1, 32'h2, 0};
        tv[12] = '{1, 32'h5, 5'd0, 0, 3'd4, 0, 1, 1, 32'h2, 0};
        tv[13] = '{0, 32'h0, 5'd1, 0, 3'd3, 0, 0, 1, 32'h3, 0};
        tv[14] = '{0, 32'h0, 5'd1, 0, 3'd2, 0, 0, 1, 32'h4, 0};
        tv[15] = '{0, 32'h0, 5'd1, 0, 3'd1, 0, 0, 1, 32'h5, 0};
        tv[16] = '{0, 32'h0, 5'd1, 0, 3'd0, 1, 0, 0, 32'h0, 0};
        tv[17] = '{0, 32'h0, 5'd1, 0, 3'd0, 1, 0, 0, 32'h0, 0};
        tv[18] = '{1, 32'h11, 5'd0, 1, 3'd0, 1, 0, 0, 32'h0, 0};
        tv[19] = '{1, 32'h11, 5'd0, 0, 3'd1, 0, 0, 1, 32'h11, 0};
        tv[20] = '{1, 32'h12, 5'd0, 1, 3'd1, 0, 0, 1, 32'h11, 0};
        tv[21] = '{1, 32'h12, 5'd0, 0, 3'd2, 0, 0, 1, 32'h11, 0};
        tv[22] = '{0, 32'h0, 5'b00110, 0, 3'd1, 0, 0, 1, 32'h12, 1};
        tv[23] = '{0, 32'h0, 5'd1, 0, 3'd0, 1, 0, 0, 32'h0, 1};
        tv[24] = '{0, 32'h0, 5'd1, 0, 3'd0, 1, 0, 0, 32'h0, 1};

        #1;
        chk("rst_cts", CTS, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_data", Data_out, 0);
        chk("rst_err", err_multi, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 25; i++) begin
            DRTS = tv[i].drts; RX = tv[i].rx; read_en = tv[i].re;
            step();
            chk($sformatf("v%0d_cts", i), CTS, tv[i].cts);
            chk($sformatf("v%0d_count", i), count, tv[i].cnt);
            chk($sformatf("v%0d_empty", i), empty, tv[i].emp);
            chk($sformatf("v%0d_full", i), full, tv[i].ful);
            chk($sformatf("v%0d_err", i), err_multi, tv[i].err);
            if (tv[i].cd) chk($sformatf("v%0d_data", i), Data_out, tv[i].dat);
        end
        DRTS = 0; read_en = 0;

        read_en = 5'b10000;
        mon_on = 1;
        for (int k = 1; k <= 10; k++) send(k);
        step(); step();
        mon_on = 0;
        read_en = 0;
        chk("wrap_len", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++) chk($sformatf("wrap_d%0d", i), got[i], i + 1);
        chk("wrap_empty", empty, 1);

        send(32'h41); send(32'h42); send(32'h43);
        chk("pre_rst_count", count, 3);
        DRTS = 1; RX = 32'h44;
        step();
        chk("mid_ack_cts", CTS, 1);
        chk("mid_ack_count", count, 3);
        #2 rst = 1;
        #1;
        chk("arst_cts", CTS, 0);
        chk("arst_count", count, 0);
        chk("arst_err", err_multi, 0);
        chk("arst_empty", empty, 1);
        chk("arst_data", Data_out, 0);
        rst = 0; DRTS = 0;
        send(32'h55);
        chk("restart_count", count, 1);
        chk("restart_data", Data_out, 32'h55);
        chk("restart_empty", empty, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
